// File: rtl/even_parity_serializer.sv
// even_parity_serializer
//   Takes a parity-coded word (data plus one even-parity bit) over a
//   valid/ready handshake and sends it as a serial frame:
//   start (0), data LSB-first, the received parity bit, then stop (1).
//   A word with odd overall parity raises a one-cycle par_err pulse and
//   bumps a saturating error counter. The word is still transmitted exactly
//   as received, so the downstream receiver sees the same fault.
module even_parity_serializer #(
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W:0]      in_word,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 done,
  output logic                 par_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  // Counter widths are kept at least one bit so that the degenerate
  // CLKS_PER_BIT=1 / DATA_W=1 builds still elaborate cleanly.
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0]    BAUD_ONE  = BAUD_W'(1);
  localparam logic [BAUD_W-1:0]    BAUD_ZERO = BAUD_W'(0);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]     IDX_ZERO  = IDX_W'(0);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX   = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE   = ERR_CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] ERR_ZERO  = ERR_CNT_W'(0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Reduction XOR over the whole coded word: 1 means odd parity, i.e. the
  // upstream generator (or the link to it) produced a bad word.
  function automatic logic word_parity(input logic [DATA_W:0] w);
    logic p;
    p = 1'b0;
    for (int i = 0; i <= int'(DATA_W); i++) begin
      p = p ^ w[i];
    end
    return p;
  endfunction

  state_e                 state_q,     state_d;
  logic [DATA_W:0]        word_q,      word_d;
  logic [IDX_W-1:0]       idx_q,       idx_d;
  logic [BAUD_W-1:0]      baud_q,      baud_d;
  logic                   tx_serial_q, tx_serial_d;
  logic                   tx_busy_q,   tx_busy_d;
  logic                   done_q,      done_d;
  logic                   par_err_q,   par_err_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

  logic                   bit_end_s;
  logic                   odd_s;
  logic [IDX_W-1:0]       idx_next_s;

  assign bit_end_s  = (baud_q == BAUD_LAST);
  assign odd_s      = word_parity(in_word);
  assign idx_next_s = idx_q + IDX_ONE;

  // Next-state, next-bit and line-value computation for the frame FSM.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    baud_d      = baud_q;
    tx_serial_d = tx_serial_q;
    tx_busy_d   = tx_busy_q;
    par_err_d   = 1'b0;
    err_count_d = err_count_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Accept edge: latch the word and drive the start bit right away.
          state_d     = ST_START;
          word_d      = in_word;
          idx_d       = IDX_ZERO;
          baud_d      = BAUD_ZERO;
          tx_serial_d = 1'b0;
          tx_busy_d   = 1'b1;
          par_err_d   = odd_s;
          if (odd_s && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + ERR_ONE;
          end else begin
            err_count_d = err_count_q;
          end
        end else begin
          tx_serial_d = 1'b1;
          tx_busy_d   = 1'b0;
        end
      end

      ST_START: begin
        if (bit_end_s) begin
          state_d     = ST_DATA;
          idx_d       = IDX_ZERO;
          baud_d      = BAUD_ZERO;
          tx_serial_d = word_q[0];
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      ST_DATA: begin
        if (bit_end_s) begin
          baud_d = BAUD_ZERO;
          if (idx_q == IDX_LAST) begin
            state_d     = ST_PARITY;
            tx_serial_d = word_q[DATA_W];
          end else begin
            idx_d       = idx_next_s;
            tx_serial_d = word_q[idx_next_s];
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      ST_PARITY: begin
        if (bit_end_s) begin
          state_d     = ST_STOP;
          baud_d      = BAUD_ZERO;
          tx_serial_d = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      ST_STOP: begin
        if (bit_end_s) begin
          state_d     = ST_IDLE;
          baud_d      = BAUD_ZERO;
          idx_d       = IDX_ZERO;
          tx_serial_d = 1'b1;
          tx_busy_d   = 1'b0;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      default: begin
        // Unreachable encodings recover to a clean idle line.
        state_d     = ST_IDLE;
        idx_d       = IDX_ZERO;
        baud_d      = BAUD_ZERO;
        tx_serial_d = 1'b1;
        tx_busy_d   = 1'b0;
      end
    endcase

    // done is registered, so it is raised on the edge that enters the
    // final stop-bit cycle (also covers CLKS_PER_BIT=1, where that is the
    // edge leaving PARITY).
    done_d = (state_d == ST_STOP) && (baud_d == BAUD_LAST);
  end

  // State and output registers; reset abandons any frame and idles the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      word_q      <= {(DATA_W + 1){1'b0}};
      idx_q       <= IDX_ZERO;
      baud_q      <= BAUD_ZERO;
      tx_serial_q <= 1'b1;
      tx_busy_q   <= 1'b0;
      done_q      <= 1'b0;
      par_err_q   <= 1'b0;
      err_count_q <= ERR_ZERO;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      baud_q      <= baud_d;
      tx_serial_q <= tx_serial_d;
      tx_busy_q   <= tx_busy_d;
      done_q      <= done_d;
      par_err_q   <= par_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign tx_serial = tx_serial_q;
  assign tx_busy   = tx_busy_q;
  assign done      = done_q;
  assign par_err   = par_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_even_parity_serializer.sv
// Directed bench for even_parity_serializer: a default instance
// (DATA_W=4, CLKS_PER_BIT=4, ERR_CNT_W=8) and a fast instance
// (CLKS_PER_BIT=1, ERR_CNT_W=2) for the saturation case.
module tb_even_parity_serializer;

  logic       clk;
  logic       rst;

  logic [4:0] in_word;
  logic       in_valid;
  logic       in_ready;
  logic       tx_serial;
  logic       tx_busy;
  logic       done;
  logic       par_err;
  logic [7:0] err_count;

  logic [4:0] in_word6;
  logic       in_valid6;
  logic       in_ready6;
  logic       tx_serial6;
  logic       tx_busy6;
  logic       done6;
  logic       par_err6;
  logic [1:0] err_count6;

  int n_checks;
  int n_pass;

  logic [4:0] w6     [5];
  logic [1:0] cnt6   [5];
  logic [6:0] line6;

  even_parity_serializer #(
    .DATA_W(4), .CLKS_PER_BIT(4), .ERR_CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid),
    .in_ready(in_ready), .tx_serial(tx_serial), .tx_busy(tx_busy),
    .done(done), .par_err(par_err), .err_count(err_count)
  );

  even_parity_serializer #(
    .DATA_W(4), .CLKS_PER_BIT(1), .ERR_CNT_W(2)
  ) dut6 (
    .clk(clk), .rst(rst), .in_word(in_word6), .in_valid(in_valid6),
    .in_ready(in_ready6), .tx_serial(tx_serial6), .tx_busy(tx_busy6),
    .done(done6), .par_err(par_err6), .err_count(err_count6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an accept edge. exp_line lists the seven frame bits,
  // first-sent bit in the MSB. Ends #1 after the edge following the frame.
  task automatic run_frame(input string tag, input logic [6:0] exp_line,
                           input logic exp_perr, input logic [7:0] exp_err);
    for (int c = 1; c <= 28; c++) begin
      check({tag, "_line"},  32'(tx_serial), 32'(exp_line[6 - (c - 1) / 4]));
      check({tag, "_done"},  32'(done),      32'(c == 28));
      check({tag, "_busy"},  32'(tx_busy),   32'd1);
      check({tag, "_ready"}, 32'(in_ready),  32'd0);
      check({tag, "_perr"},  32'(par_err),   32'((c == 1) && exp_perr));
      step();
    end
    check({tag, "_idle_line"},  32'(tx_serial), 32'd1);
    check({tag, "_idle_ready"}, 32'(in_ready),  32'd1);
    check({tag, "_idle_busy"},  32'(tx_busy),   32'd0);
    check({tag, "_idle_done"},  32'(done),      32'd0);
    check({tag, "_errcnt"},     32'(err_count), 32'(exp_err));
  endtask

  // Presents one word for a single cycle; returns #1 after the accept edge.
  task automatic present(input logic [4:0] w);
    check("pre_ready", 32'(in_ready), 32'd1);
    in_word  = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    in_word   = 5'b0_0000;
    in_valid  = 1'b0;
    in_word6  = 5'b0_0000;
    in_valid6 = 1'b0;

    w6[0] = 5'b0_0001; cnt6[0] = 2'd1;
    w6[1] = 5'b1_0000; cnt6[1] = 2'd2;
    w6[2] = 5'b0_0111; cnt6[2] = 2'd3;
    w6[3] = 5'b1_0011; cnt6[3] = 2'd3;
    w6[4] = 5'b0_1000; cnt6[4] = 2'd3;

    // 1: reset state
    rst = 1'b1;
    step();
    check("rst_line",   32'(tx_serial),  32'd1);
    check("rst_ready",  32'(in_ready),   32'd1);
    check("rst_busy",   32'(tx_busy),    32'd0);
    check("rst_done",   32'(done),       32'd0);
    check("rst_perr",   32'(par_err),    32'd0);
    check("rst_errcnt", 32'(err_count),  32'd0);
    check("rst6_line",  32'(tx_serial6), 32'd1);
    check("rst6_errcnt",32'(err_count6), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("idle_line", 32'(tx_serial), 32'd1);
    check("idle_busy", 32'(tx_busy),   32'd0);

    // 2: even-parity word 0_0011 -> 0,1,1,0,0,0,1
    present(5'b0_0011);
    run_frame("t2", 7'b0110001, 1'b0, 8'd0);

    // 3: odd-parity word 1_0011 -> 0,1,1,0,0,1,1, error flagged
    present(5'b1_0011);
    run_frame("t3", 7'b0110011, 1'b1, 8'd1);

    // 4: in_valid held; word changes right after the first accept
    check("t4_pre_ready", 32'(in_ready), 32'd1);
    in_word  = 5'b1_1010;
    in_valid = 1'b1;
    step();
    in_word  = 5'b0_0101;
    run_frame("t4a", 7'b0010111, 1'b1, 8'd2);
    step();
    in_valid = 1'b0;
    run_frame("t4b", 7'b0101001, 1'b0, 8'd2);

    // 5: reset during DATA bit 2 (frame cycle 14)
    present(5'b0_0011);
    for (int c = 1; c < 14; c++) step();
    check("t5_bit2_line", 32'(tx_serial), 32'd0);
    check("t5_pre_errcnt", 32'(err_count), 32'd2);
    rst = 1'b1;
    #1;
    check("t5_rst_line",   32'(tx_serial), 32'd1);
    check("t5_rst_ready",  32'(in_ready),  32'd1);
    check("t5_rst_busy",   32'(tx_busy),   32'd0);
    check("t5_rst_errcnt", 32'(err_count), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("t5_rst_done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      check("t5_no_done", 32'(done), 32'd0);
      check("t5_quiet_line", 32'(tx_serial), 32'd1);
    end
    present(5'b0_1001);
    run_frame("t5", 7'b0100101, 1'b0, 8'd0);

    // 6: CLKS_PER_BIT=1, 2-bit counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      check("t6_ready", 32'(in_ready6), 32'd1);
      in_word6  = w6[k];
      in_valid6 = 1'b1;
      step();
      in_valid6 = 1'b0;
      check("t6_errcnt", 32'(err_count6), 32'(cnt6[k]));
      line6 = {1'b0, w6[k][0], w6[k][1], w6[k][2], w6[k][3], w6[k][4], 1'b1};
      for (int c = 1; c <= 7; c++) begin
        check("t6_line", 32'(tx_serial6), 32'(line6[7 - c]));
        check("t6_perr", 32'(par_err6),   32'(c == 1));
        check("t6_done", 32'(done6),      32'(c == 7));
        check("t6_busy", 32'(tx_busy6),   32'd1);
        step();
      end
      check("t6_idle_busy", 32'(tx_busy6), 32'd0);
    end
    check("t6_final_errcnt", 32'(err_count6), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
